// File: rtl/chan_scan_mux_if.sv
// rtl/chan_scan_mux_if.sv - channel data, select inputs and registered outputs of chan_scan_mux
interface chan_scan_mux_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic [CHANNELS*WIDTH-1:0] ch_in;
   logic                      mode;
   logic [SEL_W-1:0]          man_sel;
   logic [WIDTH-1:0]          mux_out;
   logic [SEL_W-1:0]          cur_sel;
   logic [CHANNELS-1:0]       ch_en;
   logic                      tick;

   modport master (
      output ch_in, mode, man_sel,
      input  mux_out, cur_sel, ch_en, tick
   );

   modport slave (
      input  ch_in, mode, man_sel,
      output mux_out, cur_sel, ch_en, tick
   );
endinterface

// File: rtl/chan_scan_mux.sv
// rtl/chan_scan_mux.sv - registered N-channel mux with manual select and prescaled auto-scan
// Optional CHAN_SCAN_BLANK_EN: one blanking cycle (mux_out=0, ch_en=0) on every index change.
module chan_scan_mux #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int PRESCALE = 50000
) (
   input logic             clk,
   input logic             rst,
   chan_scan_mux_if.slave  bus
);
   localparam int                PCNT_W    = $clog2(PRESCALE);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
   localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(CHANNELS - 1);

   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic                step;
   logic                cur_in_range;
   logic                nxt_in_range;
   logic                blank;
   logic [WIDTH-1:0]    mux_d;
   logic [CHANNELS-1:0] en_d;
   logic [WIDTH-1:0]    mux_out_q;
   logic [CHANNELS-1:0] ch_en_q;
   logic                tick_q;

   assign cur_in_range = (32'(idx_q) < CHANNELS);
   assign nxt_in_range = (32'(idx_d) < CHANNELS);

   always_comb begin
      pcnt_d = '0;
      idx_d  = idx_q;
      step   = 1'b0;
      if (!bus.mode) begin
         idx_d = bus.man_sel;
      end else begin
         // An out-of-range manual index restarts the scan at channel 0.
         if (!cur_in_range) begin
            idx_d = '0;
         end
         if (pcnt_q == PCNT_LAST) begin
            step  = 1'b1;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
         end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
         end
      end
   end

   always_comb begin
      mux_d = '0;
      en_d  = '0;
      if (nxt_in_range) begin
         mux_d = bus.ch_in[32'(idx_d)*WIDTH +: WIDTH];
         en_d  = CHANNELS'(1) << idx_d;
      end
   end

`ifdef CHAN_SCAN_BLANK_EN
   assign blank = (idx_d != idx_q);
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q    <= '0;
         idx_q     <= '0;
         mux_out_q <= '0;
         ch_en_q   <= '0;
         tick_q    <= 1'b0;
      end else begin
         pcnt_q    <= pcnt_d;
         idx_q     <= idx_d;
         tick_q    <= step;
         mux_out_q <= blank ? '0 : mux_d;
         ch_en_q   <= blank ? '0 : en_d;
      end
   end

   assign bus.mux_out = mux_out_q;
   assign bus.cur_sel = idx_q;
   assign bus.ch_en   = ch_en_q;
   assign bus.tick    = tick_q;
endmodule
